// File: rtl/result_demux_1to4_pkg.sv
// Shared definitions for the result demultiplexer: default beat width and
// the destination channel indices used by the core.
package result_demux_1to4_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        DST_REGFILE = 2'd0,
        DST_MEM     = 2'd1,
        DST_PORT    = 2'd2,
        DST_DEBUG   = 2'd3
    } dst_e;

endpackage

// File: rtl/result_fifo.sv
// In-order FIFO holding {sel, data} entries for the result demultiplexer.
// Pointers wrap naturally because DEPTH is a power of two.
module result_fifo
    import result_demux_1to4_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int ENTRY_W = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [ENTRY_W-1:0]         wdata,
    output logic [ENTRY_W-1:0]         head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wptr;
    logic [PTR_W-1:0]   rptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head = mem[rptr];

    // Occupancy must stay within 0..DEPTH; the top gates push/pop to ensure it.
    always @(posedge clk) begin
        if (!rst && !flush) begin
            assert (!(pop && count == '0));
            assert (!(push && !pop && count == FULL_CNT));
        end
    end

endmodule

// File: rtl/result_demux_1to4.sv
// Registered 1-to-N result demultiplexer: buffers tagged beats and steers the
// head beat to one consumer channel. in_ready never depends on out_ready.
module result_demux_1to4
    import result_demux_1to4_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int NUM_OUT = 4,
    parameter int SEL_W   = 2,
    parameter int DEPTH   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    output logic [NUM_OUT-1:0]       out_valid,
    output logic [DATA_W-1:0]        out_data,
    input  logic [NUM_OUT-1:0]       out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [SEL_W+DATA_W-1:0] head;
    logic [SEL_W-1:0]        head_sel;
    logic [DATA_W-1:0]       head_data;
    logic [DATA_W-1:0]       last_data;
    logic                    has_head;
    logic                    push;
    logic                    pop;

    assign has_head  = (count != '0);
    assign head_sel  = head[DATA_W +: SEL_W];
    assign head_data = head[DATA_W-1:0];

    assign in_ready  = (count < FULL_CNT) && !flush && !rst;
    assign push      = in_valid && in_ready;
    assign pop       = has_head && out_ready[head_sel];

    result_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_W (SEL_W + DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata ({in_sel, in_data}),
        .head  (head),
        .count (count)
    );

    // Keep the last presented payload so out_data holds steady once the queue drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_data <= '0;
        end else if (has_head) begin
            last_data <= head_data;
        end
    end

    assign out_valid = has_head ? (NUM_OUT'(1) << head_sel) : '0;
    assign out_data  = has_head ? head_data : last_data;

endmodule
